// File: rtl/evaluate_collect.sv
// Initiator side of the board_valid/eval_valid/clear_eval handshake: launches one board to the
// evaluator bank, collects mg/eg scores serially and produces saturated sums plus a phase-tapered total.
`ifndef BOARD_WIDTH
`define BOARD_WIDTH 64
`endif

// state  | meaning
// IDLE   | ready for start; board_valid low
// LAUNCH | first board_valid cycle, timer cleared
// WAIT   | board_valid high, collecting sticky eval_valid bits until all seen or timeout
// ACCUM  | one evaluator per cycle added into the wide accumulators
// TAPER  | phase blend computed, saturated results registered
// CLEAR  | clear_eval and result_valid pulse
module evaluate_collect #(
  parameter int EVAL_WIDTH     = 32,
  parameter int NUM_EVALS      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  output logic                              ready,
  input  logic [`BOARD_WIDTH-1:0]           board_in,
  input  logic [6:0]                        phase_in,
  output logic [`BOARD_WIDTH-1:0]           board,
  output logic                              board_valid,
  output logic                              clear_eval,
  input  logic [NUM_EVALS-1:0]              eval_valid_in,
  input  logic [NUM_EVALS*EVAL_WIDTH-1:0]   eval_mg_in,
  input  logic [NUM_EVALS*EVAL_WIDTH-1:0]   eval_eg_in,
  output logic [EVAL_WIDTH-1:0]             result_mg,
  output logic [EVAL_WIDTH-1:0]             result_eg,
  output logic [EVAL_WIDTH-1:0]             result_taper,
  output logic                              result_timeout,
  output logic                              result_valid
);

  localparam int AW  = EVAL_WIDTH + 4;
  localparam int TPW = AW + 9;
  localparam int IW  = (NUM_EVALS > 1) ? $clog2(NUM_EVALS) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES);

  localparam logic signed [TPW-1:0] MAXV = {{(TPW-EVAL_WIDTH+1){1'b0}}, {(EVAL_WIDTH-1){1'b1}}};
  localparam logic signed [TPW-1:0] MINV = {{(TPW-EVAL_WIDTH+1){1'b1}}, {(EVAL_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_ACCUM, S_TAPER, S_CLEAR} state_t;

  state_t                   state, state_n;
  logic [NUM_EVALS-1:0]     sticky, sticky_n;
  logic [TW-1:0]            timer;
  logic [IW-1:0]            idx;
  logic [6:0]               phase_q, inv_phase;
  logic                     timeout_q;
  logic                     all_valid, timed_out;
  logic signed [AW-1:0]     acc_mg, acc_eg;
  logic signed [EVAL_WIDTH-1:0] cur_mg, cur_eg;
  logic signed [TPW-1:0]    mg_x, eg_x, ph_x, iph_x, taper_full, taper_shr;

  function automatic logic [EVAL_WIDTH-1:0] sat(input logic signed [TPW-1:0] v);
    if (v > MAXV)      sat = MAXV[EVAL_WIDTH-1:0];
    else if (v < MINV) sat = MINV[EVAL_WIDTH-1:0];
    else               sat = v[EVAL_WIDTH-1:0];
  endfunction

  assign sticky_n  = sticky | eval_valid_in;
  assign all_valid = &sticky_n;
  assign timed_out = (timer == TW'(TIMEOUT_CYCLES-1));
  assign cur_mg    = eval_mg_in[idx*EVAL_WIDTH +: EVAL_WIDTH];
  assign cur_eg    = eval_eg_in[idx*EVAL_WIDTH +: EVAL_WIDTH];

  // Blend is done at full width so only the final result ever saturates.
  assign inv_phase  = 7'd64 - phase_q;
  assign mg_x       = TPW'(acc_mg);
  assign eg_x       = TPW'(acc_eg);
  assign ph_x       = TPW'(phase_q);
  assign iph_x      = TPW'(inv_phase);
  assign taper_full = mg_x * ph_x + eg_x * iph_x;
  assign taper_shr  = taper_full >>> 6;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n      = state;
    ready        = 1'b0;
    board_valid  = 1'b0;
    clear_eval   = 1'b0;
    result_valid = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) state_n = S_LAUNCH;
      end
      S_LAUNCH: begin
        board_valid = 1'b1;
        state_n     = S_WAIT;
      end
      S_WAIT: begin
        board_valid = 1'b1;
        if (all_valid || timed_out) state_n = S_ACCUM;
      end
      S_ACCUM: if (idx == IW'(NUM_EVALS-1)) state_n = S_TAPER;
      S_TAPER: state_n = S_CLEAR;
      S_CLEAR: begin
        clear_eval   = 1'b1;
        result_valid = 1'b1;
        state_n      = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      board          <= '0;
      phase_q        <= '0;
      sticky         <= '0;
      timer          <= '0;
      idx            <= '0;
      timeout_q      <= 1'b0;
      acc_mg         <= '0;
      acc_eg         <= '0;
      result_mg      <= '0;
      result_eg      <= '0;
      result_taper   <= '0;
      result_timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          board     <= board_in;
          phase_q   <= (phase_in > 7'd64) ? 7'd64 : phase_in;
          sticky    <= '0;
          timer     <= '0;
          idx       <= '0;
          timeout_q <= 1'b0;
          acc_mg    <= '0;
          acc_eg    <= '0;
        end
        S_LAUNCH: timer <= '0;
        S_WAIT: begin
          sticky    <= sticky_n;
          timer     <= timer + 1'b1;
          timeout_q <= ~all_valid;
        end
        S_ACCUM: begin
          // Missing evaluators after a timeout simply contribute nothing.
          if (sticky[idx]) begin
            acc_mg <= acc_mg + AW'(cur_mg);
            acc_eg <= acc_eg + AW'(cur_eg);
          end
          idx <= idx + 1'b1;
        end
        S_TAPER: begin
          result_mg      <= sat(mg_x);
          result_eg      <= sat(eg_x);
          result_taper   <= sat(taper_shr);
          result_timeout <= timeout_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_evaluate_collect.sv
// Directed bench for evaluate_collect with behavioural evaluators and an expected-result queue.
`ifndef BOARD_WIDTH
`define BOARD_WIDTH 64
`endif

module tb_evaluate_collect;
  localparam int EW = 32;
  localparam int NE = 4;
  localparam int TO = 16;
  localparam int BW = `BOARD_WIDTH;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              ready;
  logic [BW-1:0]     board_in = '0;
  logic [6:0]        phase_in = '0;
  logic [BW-1:0]     board;
  logic              board_valid, clear_eval;
  logic [NE-1:0]     eval_valid_in;
  logic [NE*EW-1:0]  eval_mg_in = '0;
  logic [NE*EW-1:0]  eval_eg_in = '0;
  logic [EW-1:0]     result_mg, result_eg, result_taper;
  logic              result_timeout, result_valid;

  evaluate_collect #(.EVAL_WIDTH(EW), .NUM_EVALS(NE), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready),
    .board_in(board_in), .phase_in(phase_in), .board(board),
    .board_valid(board_valid), .clear_eval(clear_eval),
    .eval_valid_in(eval_valid_in), .eval_mg_in(eval_mg_in), .eval_eg_in(eval_eg_in),
    .result_mg(result_mg), .result_eg(result_eg), .result_taper(result_taper),
    .result_timeout(result_timeout), .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Behavioural evaluators: latch on a fresh board_valid rise, answer after dly cycles, idle on clear_eval.
  int   dly[NE]      = '{default: 0};
  bit   en[NE]       = '{default: 1'b1};
  logic busy[NE]     = '{default: 1'b0};
  logic vld[NE]      = '{default: 1'b0};
  int   cnt[NE]      = '{default: 0};
  int   launches[NE] = '{default: 0};
  logic bv_d = 1'b0;

  always_comb begin
    eval_valid_in = '0;
    for (int k = 0; k < NE; k++) eval_valid_in[k] = vld[k];
  end

  always @(posedge clk) begin
    for (int k = 0; k < NE; k++) begin
      if (reset || clear_eval) begin
        busy[k] <= 1'b0;
        vld[k]  <= 1'b0;
      end else if (board_valid && !bv_d && !busy[k]) begin
        busy[k]     <= 1'b1;
        cnt[k]      <= dly[k];
        launches[k] <= launches[k] + 1;
      end else if (busy[k] && !vld[k]) begin
        if (cnt[k] == 0) vld[k] <= en[k];
        else             cnt[k] <= cnt[k] - 1;
      end
    end
    bv_d <= reset ? 1'b0 : board_valid;
  end

  // Output collector and board_valid gap monitor.
  longint obs_mg[$], obs_eg[$], obs_tp[$], obs_to[$], obs_clr[$];
  int rv_count = 0, clr_count = 0, gap_viol = 0, low_run = 0;
  bit bv_any = 1'b0, bv_prev = 1'b0;

  always @(negedge clk) begin
    if (clear_eval) clr_count++;
    if (result_valid) begin
      obs_mg.push_back(longint'($signed(result_mg)));
      obs_eg.push_back(longint'($signed(result_eg)));
      obs_tp.push_back(longint'($signed(result_taper)));
      obs_to.push_back(longint'(result_timeout));
      obs_clr.push_back(longint'(clear_eval));
      rv_count++;
    end
    if (board_valid) begin
      if (!bv_prev && bv_any && low_run < 2) gap_viol++;
      bv_any  = 1'b1;
      low_run = 0;
    end else begin
      low_run++;
    end
    bv_prev = board_valid;
  end

  longint exp_mg[$], exp_eg[$], exp_tp[$], exp_to[$];
  int rd_idx = 0;

  task automatic push_exp(input longint m, input longint e, input longint t, input longint o);
    exp_mg.push_back(m); exp_eg.push_back(e); exp_tp.push_back(t); exp_to.push_back(o);
  endtask

  task automatic compare_next(input string tag);
    check({tag, "_avail"}, longint'(rv_count > rd_idx && exp_mg.size() > 0), 1);
    if (rv_count > rd_idx && exp_mg.size() > 0) begin
      check({tag, "_mg"},      obs_mg[rd_idx],  exp_mg.pop_front());
      check({tag, "_eg"},      obs_eg[rd_idx],  exp_eg.pop_front());
      check({tag, "_taper"},   obs_tp[rd_idx],  exp_tp.pop_front());
      check({tag, "_timeout"}, obs_to[rd_idx],  exp_to.pop_front());
      check({tag, "_clr"},     obs_clr[rd_idx], 1);
      rd_idx++;
    end
  endtask

  task automatic set_scores(input int m0, m1, m2, m3, e0, e1, e2, e3);
    eval_mg_in = {32'(m3), 32'(m2), 32'(m1), 32'(m0)};
    eval_eg_in = {32'(e3), 32'(e2), 32'(e1), 32'(e0)};
  endtask

  task automatic set_delays(input int d0, d1, d2, d3);
    dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
  endtask

  task automatic run_eval(input logic [6:0] ph, input logic [BW-1:0] bval, input int exp_hi,
                          input string tag);
    int n, hi, fall_at, rv_at, rv0, clr0;
    rv0 = rv_count; clr0 = clr_count;
    @(negedge clk); phase_in = ph; board_in = bval; start = 1'b1;
    @(negedge clk); start = 1'b0; board_in = ~bval;
    hi = 0; n = 0; fall_at = -1; rv_at = -1;
    while (rv_at < 0 && n < 200) begin
      if (board_valid) hi++;
      else if (hi > 0 && fall_at < 0) fall_at = n;
      if (result_valid) rv_at = n;
      if (rv_at < 0) begin n++; @(negedge clk); end
    end
    check({tag, "_done"},    longint'(rv_at >= 0), 1);
    check({tag, "_bv_high"}, hi, exp_hi);
    check({tag, "_latency"}, rv_at - fall_at, 5);
    check({tag, "_board"},   longint'(board == bval), 1);
    @(negedge clk);
    check({tag, "_rv_pulses"},  rv_count - rv0, 1);
    check({tag, "_clr_pulses"}, clr_count - clr0, 1);
    compare_next(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    int n, rv0, clr0, gv0;
    int l0[NE];

    #1;
    check("rst_ready",   longint'(ready), 1);
    check("rst_bv",      longint'(board_valid), 0);
    check("rst_clear",   longint'(clear_eval), 0);
    check("rst_rv",      longint'(result_valid), 0);
    check("rst_mg",      longint'(result_mg), 0);
    check("rst_timeout", longint'(result_timeout), 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    set_scores(10, -3, 5, 0, 20, 4, -6, 2);
    set_delays(3, 0, 7, 1);
    push_exp(12, 20, 12, 0); run_eval(7'd64,  64'hA5A5_0000_1234_5678, 10, "ph64");
    push_exp(12, 20, 20, 0); run_eval(7'd0,   64'h0000_0000_0000_0001, 10, "ph0");
    push_exp(12, 20, 16, 0); run_eval(7'd32,  64'hFFFF_0000_FFFF_0000, 10, "ph32");
    push_exp(12, 20, 12, 0); run_eval(7'd100, 64'h1234_5678_9ABC_DEF0, 10, "ph100");

    set_scores(-1, 0, 0, 0, 0, 0, 0, 0);
    push_exp(-1, 0, -1, 0);  run_eval(7'd32, 64'h0F0F_0F0F_0F0F_0F0F, 10, "floor");

    set_scores(32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 0, 0, 0, 0);
    push_exp(2147483647, 0, 2147483647, 0); run_eval(7'd64, 64'h1, 10, "sat");

    set_scores(10, -3, 5, 0, 20, 4, -6, 2);
    en[2] = 1'b0;
    push_exp(7, 26, 7, 1); run_eval(7'd64, 64'h2, TO + 1, "tmo");
    en[2] = 1'b1;

    // start held high across three back-to-back evaluations
    for (int k = 0; k < NE; k++) l0[k] = launches[k];
    rv0 = rv_count; clr0 = clr_count; gv0 = gap_viol;
    repeat (3) push_exp(12, 20, 12, 0);
    @(negedge clk); phase_in = 7'd64; board_in = 64'h3; start = 1'b1;
    n = 0;
    while (rv_count < rv0 + 3 && n < 300) begin @(negedge clk); n++; end
    start = 1'b0;
    @(negedge clk); @(negedge clk);
    check("held_rv_pulses",  rv_count - rv0, 3);
    check("held_clr_pulses", clr_count - clr0, 3);
    check("held_bv_gap",     gap_viol - gv0, 0);
    for (int k = 0; k < NE; k++) check($sformatf("held_launch%0d", k), launches[k] - l0[k], 3);
    compare_next("held0");
    compare_next("held1");
    compare_next("held2");

    // reset during WAIT
    rv0 = rv_count;
    set_delays(5, 5, 5, 5);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    check("rstw_pre_bv", longint'(board_valid), 1);
    reset = 1'b1; #1;
    check("rstw_bv",    longint'(board_valid), 0);
    check("rstw_clear", longint'(clear_eval), 0);
    check("rstw_rv",    longint'(result_valid), 0);
    check("rstw_ready", longint'(ready), 1);
    @(negedge clk); reset = 1'b0;
    check("rstw_result_cleared", longint'(result_mg), 0);

    // reset during ACCUM
    set_delays(0, 0, 0, 0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (board_valid && n < 50) begin @(negedge clk); n++; end
    check("rsta_bv_high", n, 3);
    reset = 1'b1; #1;
    check("rsta_bv",    longint'(board_valid), 0);
    check("rsta_clear", longint'(clear_eval), 0);
    check("rsta_rv",    longint'(result_valid), 0);
    @(negedge clk); reset = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_no_result", rv_count - rv0, 0);

    set_delays(3, 0, 7, 1);
    push_exp(12, 20, 12, 0); run_eval(7'd64, 64'h4, 10, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
